// File: rtl/sram_stage_sequencer.sv
// SRAM ownership sequencer: UART load, then an ordered chain of decoding stages, then VGA display.
// Build option: define SEQ_SIM_BYPASS_EN to skip the UART load after SIM_DELAY idle cycles (SRAM preloaded).
module sram_stage_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int UART_TIMEOUT = 49999999,
  parameter int TIMER_W      = 26,
  parameter int SIM_DELAY    = 10
) (
  input  logic                     CLOCK_50_I,
  input  logic                     resetn,
  input  logic                     uart_rx_i,
  input  logic                     pb_start,
  input  logic [NUM_STAGES-1:0]    stage_mask,
  input  logic [17:0]              uart_sram_address,
  input  logic [15:0]              uart_sram_write_data,
  input  logic                     uart_sram_we_n,
  output logic                     uart_rx_initialize,
  output logic                     uart_rx_enable,
  output logic                     vga_enable,
  input  logic [17:0]              vga_sram_address,
  output logic [NUM_STAGES-1:0]    stage_start,
  input  logic [NUM_STAGES-1:0]    stage_finish,
  input  logic [18*NUM_STAGES-1:0] stage_sram_address,
  input  logic [16*NUM_STAGES-1:0] stage_sram_write_data,
  input  logic [NUM_STAGES-1:0]    stage_sram_we_n,
  output logic [17:0]              sram_address,
  output logic [15:0]              sram_write_data,
  output logic                     sram_we_n,
  output logic [2:0]               active_stage,
  output logic                     busy,
  output logic [2:0]               state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UART_EN   = 3'd1,
    S_UART_WAIT = 3'd2,
    S_STAGE_RUN = 3'd3,
    S_STAGE_GAP = 3'd4
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

`ifdef SEQ_SIM_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(UART_TIMEOUT);
  localparam logic [TIMER_W-1:0] SIM_VAL     = TIMER_W'(SIM_DELAY);

  // Lowest set bit of mask at or above index 'from'.
  function automatic pick_t pick_from(input logic [NUM_STAGES-1:0] mask, input logic [3:0] from);
    pick_t p;
    p = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (mask[k] && (4'(k) >= from)) begin
        p.found = 1'b1;
        p.idx   = 3'(k);
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [2:0] idx);
    logic [NUM_STAGES-1:0] v;
    for (int k = 0; k < NUM_STAGES; k++) v[k] = (idx == 3'(k));
    return v;
  endfunction

  state_e                 state_q;
  logic [2:0]             stage_idx_q;
  logic [2:0]             active_stage_q;
  logic [NUM_STAGES-1:0]  run_mask_q;
  logic [NUM_STAGES-1:0]  start_q;
  logic                   rx_init_q;
  logic                   rx_en_q;
  logic                   vga_en_q;
  logic [TIMER_W-1:0]     timer_q;
  logic [TIMER_W-1:0]     timer_d;

  logic                   uart_start;
  logic                   bypass_fire;
  logic                   timeout_hit;
  pick_t                  first_pick;
  pick_t                  next_pick;

  logic [17:0]            stg_addr;
  logic [15:0]            stg_data;
  logic                   stg_we_n;
  logic                   stg_finish;

  assign uart_start  = ~uart_rx_i | pb_start;
  assign bypass_fire = BYPASS_EN && (timer_q == SIM_VAL);
  assign timeout_hit = (timer_q == TIMEOUT_VAL) && (uart_sram_address != 18'd0);
  assign first_pick  = pick_from(stage_mask, 4'd0);
  assign next_pick   = pick_from(run_mask_q, {1'b0, stage_idx_q} + 4'd1);

  // Idle timer: restarts on every UART write or init pulse, saturates instead of wrapping.
  always_comb begin
    // NOTE: every path assigns timer_d, so no latch is inferred.
    timer_d = timer_q;
    if (rx_init_q || !uart_sram_we_n) timer_d = '0;
    else if (!(&timer_q))             timer_d = timer_q + TIMER_W'(1);
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= timer_d;
  end

  // Bus and finish of the selected stage, picked with constant indices only.
  always_comb begin
    stg_addr   = '0;
    stg_data   = '0;
    stg_we_n   = 1'b1;
    stg_finish = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_idx_q == 3'(k)) begin
        stg_addr   = stage_sram_address[18*k +: 18];
        stg_data   = stage_sram_write_data[16*k +: 16];
        stg_we_n   = stage_sram_we_n[k];
        stg_finish = stage_finish[k];
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      stage_idx_q    <= '0;
      active_stage_q <= '0;
      run_mask_q     <= '0;
      start_q        <= '0;
      rx_init_q      <= 1'b0;
      rx_en_q        <= 1'b0;
      vga_en_q       <= 1'b1;
    end else begin
      // NOTE: nonblocking defaults make the UART controls single-cycle pulses.
      rx_init_q <= 1'b0;
      rx_en_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (uart_start) begin
            rx_init_q <= 1'b1;
            vga_en_q  <= 1'b0;
            state_q   <= S_UART_EN;
          end else if (bypass_fire) begin
            run_mask_q <= stage_mask;
            if (first_pick.found) begin
              stage_idx_q    <= first_pick.idx;
              active_stage_q <= first_pick.idx;
              start_q        <= onehot(first_pick.idx);
              vga_en_q       <= 1'b0;
              state_q        <= S_STAGE_RUN;
            end
          end
        end
        S_UART_EN: begin
          rx_en_q <= 1'b1;
          state_q <= S_UART_WAIT;
        end
        S_UART_WAIT: begin
          if (timeout_hit) begin
            rx_init_q  <= 1'b1;
            run_mask_q <= stage_mask;
            if (first_pick.found) begin
              stage_idx_q    <= first_pick.idx;
              active_stage_q <= first_pick.idx;
              start_q        <= onehot(first_pick.idx);
              state_q        <= S_STAGE_RUN;
            end else begin
              vga_en_q <= 1'b1;
              state_q  <= S_IDLE;
            end
          end
        end
        S_STAGE_RUN: begin
          if (stg_finish) begin
            start_q        <= '0;
            active_stage_q <= '0;
            state_q        <= S_STAGE_GAP;
          end
        end
        S_STAGE_GAP: begin
          if (next_pick.found) begin
            stage_idx_q    <= next_pick.idx;
            active_stage_q <= next_pick.idx;
            start_q        <= onehot(next_pick.idx);
            state_q        <= S_STAGE_RUN;
          end else begin
            vga_en_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // SRAM owner mux; write enable held inactive whenever the owner cannot write.
  always_comb begin
    sram_address    = '0;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    unique case (state_q)
      S_UART_EN, S_UART_WAIT: begin
        sram_address    = uart_sram_address;
        sram_write_data = uart_sram_write_data;
        sram_we_n       = uart_sram_we_n;
      end
      S_STAGE_RUN: begin
        sram_address    = stg_addr;
        sram_write_data = stg_data;
        sram_we_n       = stg_we_n;
      end
      S_IDLE:  sram_address = vga_sram_address;
      default: ;
    endcase
  end

  assign stage_start        = start_q;
  assign uart_rx_initialize = rx_init_q;
  assign uart_rx_enable     = rx_en_q;
  assign vga_enable         = vga_en_q;
  assign active_stage       = active_stage_q;
  assign busy               = (state_q != S_IDLE);
  assign state_o            = state_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Self-checking bench for sram_stage_sequencer: stage activations are scoreboarded against a queue
// of expected (stage, width, gap) records; control pulses and latencies are checked inline.
module tb_sram_stage_sequencer;

  localparam int N         = 3;
  localparam int TIMEOUT   = 20;
  localparam int SIM_DELAY = 10;
  localparam int FIN_DELAY = 5;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] width;
    logic [7:0] gap;     // 8'hFF: first stage of a run
    logic       bus_ok;
  } ev_t;

  logic           clk = 1'b0;
  logic           resetn;
  logic           uart_rx_i;
  logic           pb_start;
  logic [N-1:0]   stage_mask;
  logic [17:0]    uart_sram_address;
  logic [15:0]    uart_sram_write_data;
  logic           uart_sram_we_n;
  logic           uart_rx_initialize;
  logic           uart_rx_enable;
  logic           vga_enable;
  logic [17:0]    vga_sram_address;
  logic [N-1:0]   stage_start;
  logic [N-1:0]   stage_finish;
  logic [18*N-1:0] stage_sram_address;
  logic [16*N-1:0] stage_sram_write_data;
  logic [N-1:0]   stage_sram_we_n;
  logic [17:0]    sram_address;
  logic [15:0]    sram_write_data;
  logic           sram_we_n;
  logic [2:0]     active_stage;
  logic           busy;
  logic [2:0]     state_o;

  logic [N-1:0]   extra_finish;
  logic [N-1:0]   model_finish;
  int             fin_cnt [N];

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  sram_stage_sequencer #(
    .NUM_STAGES(N), .UART_TIMEOUT(TIMEOUT), .TIMER_W(26), .SIM_DELAY(SIM_DELAY)
  ) dut (
    .CLOCK_50_I(clk), .resetn(resetn), .uart_rx_i(uart_rx_i), .pb_start(pb_start),
    .stage_mask(stage_mask), .uart_sram_address(uart_sram_address),
    .uart_sram_write_data(uart_sram_write_data), .uart_sram_we_n(uart_sram_we_n),
    .uart_rx_initialize(uart_rx_initialize), .uart_rx_enable(uart_rx_enable),
    .vga_enable(vga_enable), .vga_sram_address(vga_sram_address),
    .stage_start(stage_start), .stage_finish(stage_finish),
    .stage_sram_address(stage_sram_address), .stage_sram_write_data(stage_sram_write_data),
    .stage_sram_we_n(stage_sram_we_n), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_we_n(sram_we_n),
    .active_stage(active_stage), .busy(busy), .state_o(state_o)
  );

  // Stage model: finish rises on the FIN_DELAY-th cycle of a start level.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) fin_cnt[k] <= stage_start[k] ? fin_cnt[k] + 1 : 0;
  end

  always_comb begin
    model_finish = '0;
    for (int k = 0; k < N; k++) model_finish[k] = stage_start[k] && (fin_cnt[k] == FIN_DELAY - 1);
  end

  assign stage_finish = model_finish | extra_finish;

  // Monitor: turns each start pulse into an observed record (width, preceding gap, bus ownership).
  initial begin
    logic [N-1:0] prev;
    ev_t cur;
    int  gap_cnt;
    int  ci;
    bit  fall_valid;
    prev = '0; cur = '0; gap_cnt = 0; fall_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        prev = '0;
        fall_valid = 1'b0;
      end else begin
        if (stage_start != '0) begin
          if (prev == '0) begin
            cur = '0;
            cur.bus_ok = 1'b1;
            for (int k = N - 1; k >= 0; k--) if (stage_start[k]) cur.idx = 4'(k);
            cur.gap = fall_valid ? 8'(gap_cnt) : 8'hFF;
          end
          ci = int'(cur.idx);
          cur.width = cur.width + 8'd1;
          if (stage_start !== (N'(1) << ci) || active_stage !== 3'(ci) ||
              sram_address !== stage_sram_address[18*ci +: 18] ||
              sram_write_data !== stage_sram_write_data[16*ci +: 16] ||
              sram_we_n !== stage_sram_we_n[ci])
            cur.bus_ok = 1'b0;
        end else begin
          if (prev != '0) begin
            obs_q.push_back(cur);
            fall_valid = 1'b1;
            gap_cnt = 1;
          end else begin
            gap_cnt++;
          end
          if (state_o == 3'd0) fall_valid = 1'b0;
        end
        prev = stage_start;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timed out");
  end

  function automatic void push_run(input logic [N-1:0] mask, input logic [N-1:0] early);
    ev_t e;
    bit first;
    first = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        e.idx    = 4'(k);
        e.width  = early[k] ? 8'd1 : 8'(FIN_DELAY);
        e.gap    = first ? 8'hFF : 8'd1;
        e.bus_ok = 1'b1;
        exp_q.push_back(e);
        first = 1'b0;
      end
    end
  endfunction

  task automatic start_uart(input bit use_pb);
    uart_sram_address = '0;
    uart_sram_we_n    = 1'b1;
    if (use_pb) pb_start = 1'b1;
    else        uart_rx_i = 1'b0;
    @(negedge clk);
    pb_start  = 1'b0;
    uart_rx_i = 1'b1;
  endtask

  // Three UART writes ending at address 2, then counts edges until the next init pulse.
  task automatic write_and_wait(output int lat, output bit mux_ok);
    mux_ok = 1'b1;
    for (int a = 0; a < 3; a++) begin
      uart_sram_address    = 18'(a);
      uart_sram_write_data = 16'hA5A0 + 16'(a);
      uart_sram_we_n       = 1'b0;
      #1;
      if (sram_address !== uart_sram_address || sram_write_data !== uart_sram_write_data ||
          sram_we_n !== 1'b0)
        mux_ok = 1'b0;
      @(negedge clk);
    end
    uart_sram_we_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (uart_rx_initialize === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (state_o === 3'd0 && stage_start === '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    resetn = 1'b0; uart_rx_i = 1'b1; pb_start = 1'b0; stage_mask = '0;
    uart_sram_address = '0; uart_sram_write_data = '0; uart_sram_we_n = 1'b1;
    vga_sram_address = 18'h2BEEF; extra_finish = '0;
    for (int k = 0; k < N; k++) begin
      stage_sram_address[18*k +: 18]    = 18'h10000 + 18'(k * 18'h111);
      stage_sram_write_data[16*k +: 16] = 16'hD000 + 16'(k);
      stage_sram_we_n[k]                = k[0];
    end
    repeat (3) @(negedge clk);
    got = {state_o, stage_start, uart_rx_initialize, uart_rx_enable, vga_enable, busy, active_stage};
    n_cmp++;
    if (got !== 13'b000_000_0_0_1_0_000) begin
      n_bad++;
      $display("FAIL reset_values: got %b expected %b", got, 13'b000_000_0_0_1_0_000);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sram_address, sram_write_data, sram_we_n} !== {vga_sram_address, 16'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL idle_mux: got addr=%h data=%h we_n=%b expected addr=%h data=0 we_n=1",
               sram_address, sram_write_data, sram_we_n, vga_sram_address);
    end
  endtask

  task automatic test_no_bypass();
    int active_cycles;
    active_cycles = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (stage_start !== '0 || state_o !== 3'd0) active_cycles++;
    end
    n_cmp++;
    if (active_cycles !== 0) begin
      n_bad++;
      $display("FAIL no_bypass: got %0d active cycles expected 0", active_cycles);
    end
  endtask

  task automatic test_bypass();
    int lat;
    bit ok;
    resetn = 1'b0; stage_mask = 3'b001; uart_rx_i = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (stage_start[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== SIM_DELAY + 1) begin
      n_bad++;
      $display("FAIL bypass_latency: got %0d expected %0d", lat, SIM_DELAY + 1);
    end
    n_cmp++;
    if ({state_o, vga_enable} !== {3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL bypass_state: got state=%0d vga=%b expected state=3 vga=0", state_o, vga_enable);
    end
    wait_idle(ok);
    n_cmp++;
    if ({ok, vga_enable} !== 2'b11) begin
      n_bad++;
      $display("FAIL bypass_return: got idle=%b vga=%b expected 1 1", ok, vga_enable);
    end
    obs_q.delete();
  endtask

  task automatic test_uart_load();
    int lat;
    bit mux_ok, ok;
    ev_t e, o;
    stage_mask = 3'b001;
    push_run(stage_mask, '0);
    start_uart(1'b0);
    n_cmp++;
    if ({uart_rx_initialize, vga_enable, state_o, busy} !== {1'b1, 1'b0, 3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL uart_start: got init=%b vga=%b state=%0d busy=%b expected 1 0 1 1",
               uart_rx_initialize, vga_enable, state_o, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({uart_rx_initialize, uart_rx_enable, state_o} !== {1'b0, 1'b1, 3'd2}) begin
      n_bad++;
      $display("FAIL uart_enable: got init=%b en=%b state=%0d expected 0 1 2",
               uart_rx_initialize, uart_rx_enable, state_o);
    end
    @(negedge clk);
    n_cmp++;
    if (uart_rx_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL uart_enable_pulse: got %b expected 0", uart_rx_enable);
    end
    write_and_wait(lat, mux_ok);
    n_cmp++;
    if (lat !== TIMEOUT + 1) begin
      n_bad++;
      $display("FAIL uart_timeout_latency: got %0d edges expected %0d", lat, TIMEOUT + 1);
    end
    n_cmp++;
    if (mux_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL uart_mux: got %b expected 1", mux_ok);
    end
    n_cmp++;
    if ({state_o, stage_start, active_stage} !== {3'd3, 3'b001, 3'd0}) begin
      n_bad++;
      $display("FAIL uart_to_run: got state=%0d start=%b active=%0d expected 3 001 0",
               state_o, stage_start, active_stage);
    end
    wait_idle(ok);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL uart_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL uart_event: got idx=%0d width=%0d gap=%0d bus=%b expected idx=%0d width=%0d gap=%0d bus=%b",
                 o.idx, o.width, o.gap, o.bus_ok, e.idx, e.width, e.gap, e.bus_ok);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Runs one UART-triggered chain and scoreboards every stage activation.
  task automatic test_chain(input string name, input logic [N-1:0] mask,
                            input logic [N-1:0] early, input bit use_pb);
    int lat;
    bit mux_ok, ok;
    ev_t e, o;
    stage_mask = mask;
    extra_finish = early;
    push_run(mask, early);
    start_uart(use_pb);
    @(negedge clk);
    write_and_wait(lat, mux_ok);
    wait_idle(ok);
    extra_finish = '0;
    n_cmp++;
    if ({ok, state_o, vga_enable} !== {1'b1, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL %s_end: got idle=%b state=%0d vga=%b expected 1 0 1", name, ok, state_o, vga_enable);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_event_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s_event: got idx=%0d width=%0d gap=%0d bus=%b expected idx=%0d width=%0d gap=%0d bus=%b",
                 name, o.idx, o.width, o.gap, o.bus_ok, e.idx, e.width, e.gap, e.bus_ok);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_empty_mask();
    int lat;
    bit mux_ok;
    stage_mask = '0;
    start_uart(1'b0);
    @(negedge clk);
    write_and_wait(lat, mux_ok);
    n_cmp++;
    if ({state_o, vga_enable, busy, stage_start} !== {3'd0, 1'b1, 1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL empty_mask_return: got state=%0d vga=%b busy=%b start=%b expected 0 1 0 000",
               state_o, vga_enable, busy, stage_start);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL empty_mask_starts: got %0d activations expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit mux_ok, seen;
    ev_t e, o;
    stage_mask = 3'b111;
    push_run(3'b001, '0);
    start_uart(1'b0);
    @(negedge clk);
    write_and_wait(lat, mux_ok);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stage_start[1] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_run_stage1: got %b expected 1", seen);
    end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({stage_start, state_o, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_async_drop: got start=%b state=%0d busy=%b expected 000 0 0",
               stage_start, state_o, busy);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({state_o, vga_enable, stage_start} !== {3'd0, 1'b1, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_release: got state=%0d vga=%b start=%b expected 0 1 000",
               state_o, vga_enable, stage_start);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL reset_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_event: got idx=%0d width=%0d gap=%0d bus=%b expected idx=%0d width=%0d gap=%0d bus=%b",
                 o.idx, o.width, o.gap, o.bus_ok, e.idx, e.width, e.gap, e.bus_ok);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
`ifdef SEQ_SIM_BYPASS_EN
    test_bypass();
`else
    test_no_bypass();
    test_uart_load();
    test_chain("full_chain", 3'b111, 3'b000, 1'b1);
    test_chain("sparse_mask", 3'b101, 3'b000, 1'b0);
    // Stage 0 ignores finishes of stages 1/2; stage 1 finds its finish already high.
    test_chain("finish_cases", 3'b011, 3'b110, 1'b1);
    test_empty_mask();
    test_reset_mid_run();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
